smem_req_fifo: RTL and testbench

Parametrised multi-channel request buffer between the SMEM access generators and the SMEM bank controller; next generation of the per-channel read/write request FIFOs. Each channel is an independent circular FIFO carrying an opaque packed payload ({wsel, addr} or {wsel, addr, din}), with these additions:
- guarded push/pop;
- selectable registered or first-word-fall-through output;
- almost-full threshold;
- per-channel flush;
- sticky overflow/underflow flags;
- occupancy output.

One instance serves the read side, a second instance (wider DATA_W) serves the write side.

---
 rtl/smem_req_fifo_pkg.sv | 33 +++
 rtl/smem_req_fifo_ch.sv | 120 ++++++++++++
 rtl/smem_req_fifo.sv | 74 +++++++
 tb/tb_smem_req_fifo.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/smem_req_fifo_pkg.sv
// Shared types and helpers for the SMEM request buffers.
// Callers size the FIFO payload with $bits() of the request structs below
// (or the matching *_W constants), so field changes propagate automatically.
package smem_req_fifo_pkg;

  localparam int SMEM_ADDR_W = 12;
  localparam int SMEM_WSEL_W = 2;
  localparam int NUM_PE      = 4;
  localparam int PE_DATA_W   = 16;

  typedef struct packed {
    logic [SMEM_WSEL_W-1:0] wsel;
    logic [SMEM_ADDR_W-1:0] addr;
  } smem_rd_req_t;

  typedef struct packed {
    logic [SMEM_WSEL_W-1:0]             wsel;
    logic [SMEM_ADDR_W-1:0]             addr;
    logic [NUM_PE-1:0][PE_DATA_W-1:0]   din;
  } smem_wr_req_t;

  localparam int SMEM_RD_REQ_W = $bits(smem_rd_req_t);
  localparam int SMEM_WR_REQ_W = $bits(smem_wr_req_t);

  function automatic bit is_pow2(int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit afull_th_ok(int th, int depth);
    return (th >= 1) && (th <= depth);
  endfunction

endpackage

// File: rtl/smem_req_fifo_ch.sv
// Single-channel circular request FIFO.
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   flush            synchronous clear of pointers/count/dout_vld
//   err_clr          clears sticky ovf/udf (a same-cycle error set wins)
//   push, din        enqueue request and payload
//   pop              dequeue request
//   dout, dout_vld   head payload (registered or fall-through per FWFT)
//   empty/full/afull status decoded from count
//   count            current occupancy
//   ovf, udf         sticky overflow / underflow
module smem_req_fifo_ch
  import smem_req_fifo_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int DEPTH    = 4,
  parameter int FWFT     = 0,
  parameter int AFULL_TH = DEPTH - 1,
  localparam int CNT_BW  = $clog2(DEPTH + 1),
  localparam int PTR_BW  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  logic              err_clr,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              dout_vld,
  output logic              empty,
  output logic              full,
  output logic              afull,
  output logic [CNT_BW-1:0] count,
  output logic              ovf,
  output logic              udf
);

  if (!afull_th_ok(AFULL_TH, DEPTH)) begin : g_chk_afull
    $error("smem_req_fifo_ch: AFULL_TH must be in 1..DEPTH");
  end

  localparam logic [CNT_BW-1:0] DEPTH_C = CNT_BW'(DEPTH);
  localparam logic [CNT_BW-1:0] AFULL_C = CNT_BW'(AFULL_TH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_BW-1:0] head;
  logic [PTR_BW-1:0] tail;
  logic [CNT_BW-1:0] cnt;
  logic              pop_ok;
  logic              push_ok;

  assign empty = (cnt == '0);
  assign full  = (cnt == DEPTH_C);
  assign afull = (cnt >= AFULL_C);
  assign count = cnt;

  // No bypass: a pop on an empty FIFO is rejected even if a push arrives
  // in the same cycle. A push at full succeeds only alongside a real pop.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push_ok) tail <= tail + PTR_BW'(1);
      if (pop_ok)  head <= head + PTR_BW'(1);
      if (push_ok && !pop_ok)      cnt <= cnt + CNT_BW'(1);
      else if (pop_ok && !push_ok) cnt <= cnt - CNT_BW'(1);
    end
  end

  // Requests discarded by flush never raise an error.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      ovf <= (~flush & push & ~push_ok) | (ovf & ~err_clr);
      udf <= (~flush & pop & ~pop_ok)   | (udf & ~err_clr);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[tail] <= din;
  end

  if (FWFT != 0) begin : g_fwft
    // Gate the head so an empty FIFO (including just after reset) shows 0
    // rather than uninitialised storage.
    assign dout     = empty ? '0 : mem[head];
    assign dout_vld = ~empty;
  end else begin : g_reg
    logic [DATA_W-1:0] dout_q;
    logic              vld_q;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        dout_q <= '0;
        vld_q  <= 1'b0;
      end else if (flush) begin
        vld_q  <= 1'b0;
      end else begin
        vld_q <= pop_ok;
        if (pop_ok) dout_q <= mem[head];
      end
    end

    assign dout     = dout_q;
    assign dout_vld = vld_q;
  end

endmodule

// File: rtl/smem_req_fifo.sv
// Multi-channel SMEM request buffer: NUM_CH independent FIFOs sharing only
// clock, reset and err_clr. Vector ports are flat, channel ch occupies
// bits [ch*W +: W] of each multi-bit-per-channel port.
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   flush[NUM_CH]    per-channel synchronous clear
//   err_clr          clears all sticky error flags
//   push/din         enqueue request and payload per channel
//   pop              dequeue request per channel
//   dout/dout_vld    head payload and valid per channel
//   empty/full/afull status per channel
//   count            occupancy per channel (CNT_BW bits each)
//   ovf/udf          sticky overflow / underflow per channel
module smem_req_fifo
  import smem_req_fifo_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int DATA_W   = 64,
  parameter int DEPTH    = 4,
  parameter int FWFT     = 0,
  parameter int AFULL_TH = DEPTH - 1,
  localparam int CNT_BW  = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NUM_CH-1:0]        flush,
  input  logic                     err_clr,
  input  logic [NUM_CH-1:0]        push,
  input  logic [NUM_CH*DATA_W-1:0] din,
  input  logic [NUM_CH-1:0]        pop,
  output logic [NUM_CH*DATA_W-1:0] dout,
  output logic [NUM_CH-1:0]        dout_vld,
  output logic [NUM_CH-1:0]        empty,
  output logic [NUM_CH-1:0]        full,
  output logic [NUM_CH-1:0]        afull,
  output logic [NUM_CH*CNT_BW-1:0] count,
  output logic [NUM_CH-1:0]        ovf,
  output logic [NUM_CH-1:0]        udf
);

  if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_chk_depth
    $error("smem_req_fifo: DEPTH must be a power of 2 and >= 2");
  end

  if (NUM_CH < 1) begin : g_chk_nch
    $error("smem_req_fifo: NUM_CH must be >= 1");
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    smem_req_fifo_ch #(
      .DATA_W   (DATA_W),
      .DEPTH    (DEPTH),
      .FWFT     (FWFT),
      .AFULL_TH (AFULL_TH)
    ) u_ch (
      .clk      (clk),
      .rstn     (rstn),
      .flush    (flush[ch]),
      .err_clr  (err_clr),
      .push     (push[ch]),
      .din      (din[ch*DATA_W +: DATA_W]),
      .pop      (pop[ch]),
      .dout     (dout[ch*DATA_W +: DATA_W]),
      .dout_vld (dout_vld[ch]),
      .empty    (empty[ch]),
      .full     (full[ch]),
      .afull    (afull[ch]),
      .count    (count[ch*CNT_BW +: CNT_BW]),
      .ovf      (ovf[ch]),
      .udf      (udf[ch])
    );
  end

endmodule

// File: tb/tb_smem_req_fifo.sv
module tb_smem_req_fifo;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        err_clr = 1'b0;

  // Two-channel registered-output instance
  logic [1:0]  flush = '0, push = '0, pop = '0;
  logic [15:0] din = '0;
  logic [15:0] dout;
  logic [1:0]  dout_vld, empty, full, afull, ovf, udf;
  logic [5:0]  count;

  // Single-channel fall-through instance
  logic        f_flush = 1'b0, f_push = 1'b0, f_pop = 1'b0;
  logic [7:0]  f_din = '0;
  logic [7:0]  f_dout;
  logic        f_dout_vld, f_empty, f_full, f_afull, f_ovf, f_udf;
  logic [2:0]  f_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  smem_req_fifo #(.NUM_CH(2), .DATA_W(8), .DEPTH(4), .FWFT(0), .AFULL_TH(3)) dut (
    .clk(clk), .rstn(rstn), .flush(flush), .err_clr(err_clr),
    .push(push), .din(din), .pop(pop), .dout(dout), .dout_vld(dout_vld),
    .empty(empty), .full(full), .afull(afull), .count(count),
    .ovf(ovf), .udf(udf)
  );

  smem_req_fifo #(.NUM_CH(1), .DATA_W(8), .DEPTH(4), .FWFT(1), .AFULL_TH(3)) dutf (
    .clk(clk), .rstn(rstn), .flush(f_flush), .err_clr(err_clr),
    .push(f_push), .din(f_din), .pop(f_pop), .dout(f_dout), .dout_vld(f_dout_vld),
    .empty(f_empty), .full(f_full), .afull(f_afull), .count(f_count),
    .ovf(f_ovf), .udf(f_udf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (count !== 6'd0)      begin errors++; $display("FAIL reset_count got=%h exp=0", count); end
    checks++; if (empty !== 2'b11)     begin errors++; $display("FAIL reset_empty got=%b exp=11", empty); end
    checks++; if (full !== 2'b00 || afull !== 2'b00) begin errors++; $display("FAIL reset_full_afull got=%b/%b exp=00/00", full, afull); end
    checks++; if (ovf !== 2'b00 || udf !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b/%b exp=00/00", ovf, udf); end
    checks++; if (dout !== 16'h0 || dout_vld !== 2'b00) begin errors++; $display("FAIL reset_dout got=%h/%b exp=0000/00", dout, dout_vld); end
    checks++; if (f_dout !== 8'h0 || f_dout_vld !== 1'b0 || f_empty !== 1'b1) begin errors++; $display("FAIL reset_fwft got=%h/%b/%b exp=00/0/1", f_dout, f_dout_vld, f_empty); end
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_fill_ovf();
    for (int i = 0; i < 4; i++) begin
      push[0] = 1'b1; din[7:0] = 8'hA0 + 8'(i);
      tick();
      push[0] = 1'b0;
      if (i == 2) begin
        checks++; if (afull[0] !== 1'b1 || full[0] !== 1'b0) begin errors++; $display("FAIL afull_at3 got=%b/%b exp=1/0", afull[0], full[0]); end
      end
    end
    checks++; if (count[2:0] !== 3'd4 || full[0] !== 1'b1 || afull[0] !== 1'b1) begin errors++; $display("FAIL full_at4 got=%0d/%b/%b exp=4/1/1", count[2:0], full[0], afull[0]); end
    push[0] = 1'b1; din[7:0] = 8'hEE;
    tick();
    push[0] = 1'b0;
    checks++; if (ovf[0] !== 1'b1 || count[2:0] !== 3'd4 || ovf[1] !== 1'b0) begin errors++; $display("FAIL overflow got=ovf%b cnt%0d exp=ovf01 cnt4", ovf, count[2:0]); end
    for (int i = 0; i < 4; i++) begin
      pop[0] = 1'b1;
      tick();
      pop[0] = 1'b0;
      checks++; if (dout[7:0] !== 8'hA0 + 8'(i) || dout_vld[0] !== 1'b1) begin errors++; $display("FAIL pop_order%0d got=%h/%b exp=%h/1", i, dout[7:0], dout_vld[0], 8'hA0 + 8'(i)); end
    end
    tick();
    checks++; if (dout_vld[0] !== 1'b0 || empty[0] !== 1'b1 || dout[7:0] !== 8'hA3) begin errors++; $display("FAIL drained got=%b/%b/%h exp=0/1/a3", dout_vld[0], empty[0], dout[7:0]); end
  endtask

  task automatic test_push_pop_full();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++; if (ovf !== 2'b00) begin errors++; $display("FAIL err_clr got=%b exp=00", ovf); end
    for (int i = 0; i < 4; i++) begin
      push[0] = 1'b1; din[7:0] = 8'h10 + 8'(i);
      tick();
    end
    push[0] = 1'b1; pop[0] = 1'b1; din[7:0] = 8'hB0;
    tick();
    push[0] = 1'b0; pop[0] = 1'b0;
    checks++; if (dout[7:0] !== 8'h10 || count[2:0] !== 3'd4 || ovf[0] !== 1'b0) begin errors++; $display("FAIL full_pushpop got=%h/%0d/%b exp=10/4/0", dout[7:0], count[2:0], ovf[0]); end
    for (int i = 0; i < 4; i++) begin
      logic [7:0] exp;
      exp = (i == 3) ? 8'hB0 : 8'h11 + 8'(i);
      pop[0] = 1'b1;
      tick();
      pop[0] = 1'b0;
      checks++; if (dout[7:0] !== exp) begin errors++; $display("FAIL wrap_pop%0d got=%h exp=%h", i, dout[7:0], exp); end
    end
  endtask

  task automatic test_underflow_ch1();
    push[1] = 1'b1; pop[1] = 1'b1; din[15:8] = 8'hC0;
    tick();
    push[1] = 1'b0; pop[1] = 1'b0;
    checks++; if (udf !== 2'b10 || count[5:3] !== 3'd1 || dout_vld[1] !== 1'b0) begin errors++; $display("FAIL underflow got=udf%b cnt%0d vld%b exp=udf10 cnt1 vld0", udf, count[5:3], dout_vld[1]); end
    pop[1] = 1'b1;
    tick();
    pop[1] = 1'b0;
    checks++; if (dout[15:8] !== 8'hC0 || dout_vld[1] !== 1'b1 || count[5:3] !== 3'd0) begin errors++; $display("FAIL udf_pop got=%h/%b/%0d exp=c0/1/0", dout[15:8], dout_vld[1], count[5:3]); end
  endtask

  task automatic test_fwft();
    tick();
    checks++; if (f_dout_vld !== 1'b0 || f_empty !== 1'b1) begin errors++; $display("FAIL fwft_idle got=%b/%b exp=0/1", f_dout_vld, f_empty); end
    f_push = 1'b1; f_din = 8'hD0;
    tick();
    f_push = 1'b0;
    checks++; if (f_dout !== 8'hD0 || f_dout_vld !== 1'b1 || f_empty !== 1'b0) begin errors++; $display("FAIL fwft_show got=%h/%b/%b exp=d0/1/0", f_dout, f_dout_vld, f_empty); end
    f_pop = 1'b1;
    tick();
    f_pop = 1'b0;
    checks++; if (f_empty !== 1'b1 || f_dout_vld !== 1'b0 || f_count !== 3'd0 || f_udf !== 1'b0) begin errors++; $display("FAIL fwft_pop got=%b/%b/%0d/%b exp=1/0/0/0", f_empty, f_dout_vld, f_count, f_udf); end
  endtask

  task automatic test_flush();
    push = 2'b11; din = {8'h40, 8'h30};
    tick();
    push = 2'b01; din[7:0] = 8'h31;
    tick();
    din[7:0] = 8'h32;
    tick();
    push[0] = 1'b1; pop[0] = 1'b1; din[7:0] = 8'h33;
    tick();
    checks++; if (count[2:0] !== 3'd3 || dout[7:0] !== 8'h30 || dout_vld[0] !== 1'b1) begin errors++; $display("FAIL preflush got=%0d/%h/%b exp=3/30/1", count[2:0], dout[7:0], dout_vld[0]); end
    flush[0] = 1'b1; push[0] = 1'b1; pop[0] = 1'b0; din[7:0] = 8'h34; pop[1] = 1'b1;
    tick();
    flush = '0; push = '0; pop = '0;
    checks++; if (count[2:0] !== 3'd0 || empty[0] !== 1'b1 || dout_vld[0] !== 1'b0 || ovf[0] !== 1'b0) begin errors++; $display("FAIL flush_ch0 got=%0d/%b/%b/%b exp=0/1/0/0", count[2:0], empty[0], dout_vld[0], ovf[0]); end
    checks++; if (dout[15:8] !== 8'h40 || dout_vld[1] !== 1'b1 || count[5:3] !== 3'd0 || udf !== 2'b10) begin errors++; $display("FAIL flush_ch1 got=%h/%b/%0d/udf%b exp=40/1/0/udf10", dout[15:8], dout_vld[1], count[5:3], udf); end
    push[0] = 1'b1; din[7:0] = 8'h55;
    tick();
    push[0] = 1'b0; pop[0] = 1'b1;
    tick();
    pop[0] = 1'b0;
    checks++; if (dout[7:0] !== 8'h55 || dout_vld[0] !== 1'b1 || empty[0] !== 1'b1) begin errors++; $display("FAIL postflush got=%h/%b/%b exp=55/1/1", dout[7:0], dout_vld[0], empty[0]); end
  endtask

  task automatic test_async_reset();
    push = 2'b11; din = {8'h61, 8'h60}; f_push = 1'b1; f_din = 8'h62;
    tick();
    push = '0; f_push = 1'b0; pop[0] = 1'b1;
    tick();
    pop[0] = 1'b0;
    checks++; if (dout[7:0] !== 8'h60 || dout_vld[0] !== 1'b1 || count[5:3] !== 3'd1) begin errors++; $display("FAIL prereset got=%h/%b/%0d exp=60/1/1", dout[7:0], dout_vld[0], count[5:3]); end
    #2;
    rstn = 1'b0;
    #1;
    checks++; if (count !== 6'd0 || empty !== 2'b11 || full !== 2'b00) begin errors++; $display("FAIL async_status got=%h/%b/%b exp=00/11/00", count, empty, full); end
    checks++; if (dout !== 16'h0 || dout_vld !== 2'b00 || udf !== 2'b00 || ovf !== 2'b00) begin errors++; $display("FAIL async_out got=%h/%b/udf%b/ovf%b exp=0000/00/00/00", dout, dout_vld, udf, ovf); end
    checks++; if (f_count !== 3'd0 || f_dout_vld !== 1'b0 || f_dout !== 8'h0) begin errors++; $display("FAIL async_fwft got=%0d/%b/%h exp=0/0/00", f_count, f_dout_vld, f_dout); end
    #1;
    rstn = 1'b1;
    tick();
    push[0] = 1'b1; din[7:0] = 8'h77;
    tick();
    push[0] = 1'b0; pop[0] = 1'b1;
    tick();
    pop[0] = 1'b0;
    checks++; if (dout[7:0] !== 8'h77 || dout_vld[0] !== 1'b1 || empty[0] !== 1'b1) begin errors++; $display("FAIL roundtrip got=%h/%b/%b exp=77/1/1", dout[7:0], dout_vld[0], empty[0]); end
  endtask

  initial begin
    test_reset();
    test_fill_ovf();
    test_push_pop_full();
    test_underflow_ch1();
    test_fwft();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
